event_phase_fsm: RTL and testbench



---
 rtl/event_phase_fsm.sv | 108 ++++++++++
 tb/tb_event_phase_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/event_phase_fsm.sv
// event_phase_fsm
//   Generic phase/sequence tracker on a single-bit control input. The phase
//   advances by one on every qualified input event and wraps to 0 after the
//   last phase. `out` flags phases that fall inside a programmable window,
//   which may itself wrap around the end of the phase range.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-low reset
//   en      event enable; the phase holds while en=0
//   clr     synchronous clear of phase and wrap counter (wins over events)
//   in      event input
//   out     window output (Mealy: from next phase, Moore: from current phase)
//   state   current phase, registered
//   wrap    one-cycle pulse in the cycle after a last->0 wrap
//   cycles  saturating count of wraps
module event_phase_fsm #(
    parameter  int NUM_STATES = 4,
    parameter  int OUT_LO     = 2,
    parameter  int OUT_HI     = 3,
    parameter  int MEALY      = 1,
    parameter  int EDGE_MODE  = 0,
    parameter  int CNT_W      = 8,
    localparam int ST_W       = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in,
    output logic             out,
    output logic [ST_W-1:0]  state,
    output logic             wrap,
    output logic [CNT_W-1:0] cycles
);

    if (NUM_STATES < 2 || NUM_STATES > 256 ||
        OUT_LO < 0 || OUT_HI < 0 ||
        OUT_LO >= NUM_STATES || OUT_HI >= NUM_STATES) begin : g_bad_params
        $error("event_phase_fsm: illegal NUM_STATES/OUT_LO/OUT_HI combination");
    end

    localparam logic [ST_W-1:0] LAST = ST_W'(NUM_STATES - 1);

    // Window membership; OUT_LO > OUT_HI selects a window that wraps past
    // the last phase back into phase 0.
    function automatic logic win(input logic [ST_W-1:0] s);
        int v;
        v = int'(s);
        if (OUT_LO <= OUT_HI)
            return (v >= OUT_LO) && (v <= OUT_HI);
        else
            return (v >= OUT_LO) || (v <= OUT_HI);
    endfunction

    logic            in_d;
    logic            ev;
    logic            last;
    logic            wrap_cond;
    logic [ST_W-1:0] nxt;

    // en gates `in` first so an undriven input cannot leak X while disabled.
    // In edge mode an edge seen while en=0 is simply dropped.
    assign ev        = en & in & ((EDGE_MODE == 0) | ~in_d);
    assign last      = (state == LAST);
    assign wrap_cond = ~clr & ev & last;

    always_comb begin
        nxt = state;
        if (clr)
            nxt = '0;
        else if (ev)
            nxt = last ? '0 : state + ST_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_d   <= 1'b0;
            state  <= '0;
            wrap   <= 1'b0;
            cycles <= '0;
        end else begin
            in_d  <= in;
            state <= nxt;
            wrap  <= wrap_cond;
            if (clr)
                cycles <= '0;
            else if (wrap_cond && !(&cycles))
                cycles <= cycles + CNT_W'(1);
        end
    end

    if (MEALY != 0) begin : g_mealy
        // Combinational from the next phase; forced low while in reset so the
        // output never reflects a phase that the registers are not holding.
        assign out = rst & win(nxt);
    end else begin : g_moore
        logic out_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                out_q <= 1'b0;
            else
                out_q <= win(nxt);
        end
        assign out = out_q;
    end

endmodule

// File: tb/tb_event_phase_fsm.sv
// tb_event_phase_fsm
//   Directed bench for event_phase_fsm. Five instances with different
//   parameter sets share clock and reset; each has its own control inputs:
//     a: defaults (Mealy)        b: MEALY=0 (shares inputs with a)
//     c: EDGE_MODE=1             d: NUM_STATES=5, window 4..0 (wrapping)
//     e: CNT_W=2
module tb_event_phase_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       en1 = 1'b0, clr1 = 1'b0, in1 = 1'b0;
    logic       out_a, wrap_a, out_b, wrap_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cycles_a, cycles_b;

    logic       en_c = 1'b0, clr_c = 1'b0, in_c = 1'b0;
    logic       out_c, wrap_c;
    logic [1:0] state_c;
    logic [7:0] cycles_c;

    logic       en_d = 1'b0, clr_d = 1'b0, in_d = 1'b0;
    logic       out_d, wrap_d;
    logic [2:0] state_d;
    logic [7:0] cycles_d;

    logic       en_e = 1'b0, clr_e = 1'b0, in_e = 1'b0;
    logic       out_e, wrap_e;
    logic [1:0] state_e;
    logic [1:0] cycles_e;

    event_phase_fsm u_a (.clk(clk), .rst(rst), .en(en1), .clr(clr1), .in(in1),
                         .out(out_a), .state(state_a), .wrap(wrap_a), .cycles(cycles_a));

    event_phase_fsm #(.MEALY(0)) u_b (.clk(clk), .rst(rst), .en(en1), .clr(clr1), .in(in1),
                         .out(out_b), .state(state_b), .wrap(wrap_b), .cycles(cycles_b));

    event_phase_fsm #(.EDGE_MODE(1)) u_c (.clk(clk), .rst(rst), .en(en_c), .clr(clr_c), .in(in_c),
                         .out(out_c), .state(state_c), .wrap(wrap_c), .cycles(cycles_c));

    event_phase_fsm #(.NUM_STATES(5), .OUT_LO(4), .OUT_HI(0)) u_d (.clk(clk), .rst(rst),
                         .en(en_d), .clr(clr_d), .in(in_d),
                         .out(out_d), .state(state_d), .wrap(wrap_d), .cycles(cycles_d));

    event_phase_fsm #(.CNT_W(2)) u_e (.clk(clk), .rst(rst), .en(en_e), .clr(clr_e), .in(in_e),
                         .out(out_e), .state(state_e), .wrap(wrap_e), .cycles(cycles_e));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       exp_out_a [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_out_b [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_st    [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_out_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] exp_st_d  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0] exp_cyc_e [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset state, before any clock edge
        #2;
        check("rst_state_a", 32'(state_a), 0);
        check("rst_out_a", 32'(out_a), 0);
        check("rst_out_b", 32'(out_b), 0);
        check("rst_wrap_a", 32'(wrap_a), 0);
        check("rst_cycles_a", 32'(cycles_a), 0);
        check("rst_out_d_gated", 32'(out_d), 0);
        #1 rst = 1'b1;
        tick();

        // Defaults vs MEALY=0, event every cycle
        en1 = 1'b1; in1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mealy_out_%0d", i), 32'(out_a), 32'(exp_out_a[i]));
            check($sformatf("moore_out_%0d", i), 32'(out_b), 32'(exp_out_b[i]));
            tick();
            check($sformatf("state_a_%0d", i), 32'(state_a), 32'(exp_st[i]));
            check($sformatf("state_b_%0d", i), 32'(state_b), 32'(exp_st[i]));
            check($sformatf("wrap_a_%0d", i), 32'(wrap_a), (i == 3) ? 1 : 0);
            check($sformatf("wrap_b_%0d", i), 32'(wrap_b), (i == 3) ? 1 : 0);
        end
        check("cycles_a", 32'(cycles_a), 1);
        check("cycles_b", 32'(cycles_b), 1);
        en1 = 1'b0; in1 = 1'b0;

        // Edge mode: held-high input counts once
        en_c = 1'b1; in_c = 1'b1;
        tick();
        check("edge_first", 32'(state_c), 1);
        repeat (5) tick();
        check("edge_held", 32'(state_c), 1);
        in_c = 1'b0;
        tick();
        in_c = 1'b1;
        tick();
        check("edge_second", 32'(state_c), 2);
        in_c = 1'b0;
        tick();
        // Edge while disabled is lost, not deferred
        en_c = 1'b0; in_c = 1'b1;
        tick();
        en_c = 1'b1;
        tick();
        check("edge_lost", 32'(state_c), 2);
        in_c = 1'b0;
        tick();
        in_c = 1'b1;
        tick();
        check("edge_after_lost", 32'(state_c), 3);
        en_c = 1'b0; in_c = 1'b0;

        // Wrap-around window on 5 phases
        en_d = 1'b1; in_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("win_out_d_%0d", i), 32'(out_d), 32'(exp_out_d[i]));
            tick();
            check($sformatf("state_d_%0d", i), 32'(state_d), 32'(exp_st_d[i]));
            check($sformatf("wrap_d_%0d", i), 32'(wrap_d), (i == 4) ? 1 : 0);
        end
        check("cycles_d", 32'(cycles_d), 1);
        repeat (4) tick();
        check("state_d_at4", 32'(state_d), 4);
        clr_d = 1'b1;
        tick();
        check("clr_state_d", 32'(state_d), 0);
        check("clr_wrap_d", 32'(wrap_d), 0);
        check("clr_cycles_d", 32'(cycles_d), 0);
        clr_d = 1'b0;
        repeat (2) tick();
        check("state_d_at2", 32'(state_d), 2);
        #1;
        check("out_d_no_clr", 32'(out_d), 0);
        clr_d = 1'b1;
        #1;
        check("out_d_clr_same_cycle", 32'(out_d), 1);
        clr_d = 1'b0; en_d = 1'b0; in_d = 1'b0;
        tick();
        check("state_d_hold", 32'(state_d), 2);

        // Saturating wrap counter, CNT_W=2
        en_e = 1'b1; in_e = 1'b1;
        for (int r = 0; r < 5; r++) begin
            repeat (4) tick();
            check($sformatf("cycles_e_%0d", r), 32'(cycles_e), 32'(exp_cyc_e[r]));
        end
        tick();
        check("state_e_1", 32'(state_e), 1);
        en_e = 1'b0;
        repeat (10) tick();
        check("state_e_hold", 32'(state_e), 1);
        check("cycles_e_hold", 32'(cycles_e), 3);
        in_e = 1'b0;

        // Asynchronous reset in mid-cycle
        en1 = 1'b1; in1 = 1'b1;
        repeat (2) tick();
        in1 = 1'b0;
        #1;
        check("pre_rst_state_a", 32'(state_a), 3);
        check("pre_rst_out_a", 32'(out_a), 1);
        check("pre_rst_out_b", 32'(out_b), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_state_a", 32'(state_a), 0);
        check("mid_rst_out_a", 32'(out_a), 0);
        check("mid_rst_out_b", 32'(out_b), 0);
        check("mid_rst_wrap_a", 32'(wrap_a), 0);
        check("mid_rst_cycles_a", 32'(cycles_a), 0);
        check("mid_rst_cycles_e", 32'(cycles_e), 0);
        check("mid_rst_out_d", 32'(out_d), 0);
        #1 rst = 1'b1;
        in1 = 1'b1;
        tick();
        check("post_rst_state_a", 32'(state_a), 1);
        en1 = 1'b0; in1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
